// File: rtl/fwd_hazard_unit_if.sv
// Pipeline-side bundle for fwd_hazard_unit: ID/EX/MEM/WB register
// fields in, forwarding selects, stall and stall statistics out.
interface fwd_hazard_unit_if #(
  parameter int REG_AW = 5,
  parameter int STAT_W = 16
);
  logic [REG_AW-1:0] IdRs;
  logic [REG_AW-1:0] IdRt;
  logic              IdUsesRt;
  logic              ExMemRead;
  logic              ExWb;
  logic [REG_AW-1:0] ExRd;
  logic [REG_AW-1:0] ExRs;
  logic [REG_AW-1:0] ExRt;
  logic              MemWb;
  logic [REG_AW-1:0] MemRd;
  logic              WbWb;
  logic [REG_AW-1:0] WbRd;
  logic              flush;
  logic [1:0]        selA;
  logic [1:0]        selB;
  logic              stall;
  logic [STAT_W-1:0] stallCnt;

  modport master (
    output IdRs, IdRt, IdUsesRt,
    output ExMemRead, ExWb, ExRd, ExRs, ExRt,
    output MemWb, MemRd, WbWb, WbRd, flush,
    input  selA, selB, stall, stallCnt
  );

  modport slave (
    input  IdRs, IdRt, IdUsesRt,
    input  ExMemRead, ExWb, ExRd, ExRs, ExRt,
    input  MemWb, MemRd, WbWb, WbRd, flush,
    output selA, selB, stall, stallCnt
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// EX operand forwarding plus load-use stall controller with
// configurable load latency, flush abort and saturating stall counter.
// Ports: clk, rst (async, active-low), bus (fwd_hazard_unit_if.slave).
module fwd_hazard_unit #(
  parameter int REG_AW  = 5,
  parameter int MEM_LAT = 1,
  parameter int STAT_W  = 16
) (
  input  logic clk,
  input  logic rst,
  fwd_hazard_unit_if.slave bus
);

  typedef enum logic {
    IDLE,
    STALL
  } state_t;

  localparam bit HAS_LAT = (MEM_LAT > 0);
  localparam int LOADV = HAS_LAT ? MEM_LAT - 1 : 0;
  localparam logic [2:0] CNT_LOAD = 3'(LOADV);
  localparam logic [STAT_W-1:0] ONE = STAT_W'(1);

  state_t      state;
  state_t      stateNxt;
  logic [2:0]  cnt;
  logic [2:0]  cntNxt;
  logic        stallRaw;
  logic        hazard;
  logic [STAT_W-1:0] statQ;

  logic memA;
  logic memB;
  logic wbA;
  logic wbB;

  assign memA = bus.MemWb && (bus.MemRd != '0)
              && (bus.MemRd == bus.ExRs);
  assign memB = bus.MemWb && (bus.MemRd != '0)
              && (bus.MemRd == bus.ExRt);
  assign wbA  = bus.WbWb && (bus.WbRd != '0)
              && (bus.WbRd == bus.ExRs);
  assign wbB  = bus.WbWb && (bus.WbRd != '0)
              && (bus.WbRd == bus.ExRt);

  // MEM holds the younger result, so it wins over WB.
  always_comb begin
    bus.selA = 2'b00;
    priority case (1'b1)
      memA:    bus.selA = 2'b01;
      wbA:     bus.selA = 2'b10;
      default: bus.selA = 2'b00;
    endcase
  end

  always_comb begin
    bus.selB = 2'b00;
    priority case (1'b1)
      memB:    bus.selB = 2'b01;
      wbB:     bus.selB = 2'b10;
      default: bus.selB = 2'b00;
    endcase
  end

  assign hazard = bus.ExMemRead && bus.ExWb
                && (bus.ExRd != '0)
                && ((bus.ExRd == bus.IdRs)
                 || (bus.IdUsesRt && (bus.ExRd == bus.IdRt)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= stateNxt;
      cnt   <= cntNxt;
    end
  end

  // First stall cycle is raised in IDLE; STALL covers the
  // remaining MEM_LAT cycles, counted down through cnt.
  always_comb begin
    stateNxt = state;
    cntNxt   = cnt;
    stallRaw = 1'b0;
    if (bus.flush) begin
      stateNxt = IDLE;
      cntNxt   = 3'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (hazard) begin
            stallRaw = 1'b1;
            if (HAS_LAT) begin
              stateNxt = STALL;
              cntNxt   = CNT_LOAD;
            end
          end
        end
        STALL: begin
          stallRaw = 1'b1;
          if (cnt == 3'd0) begin
            stateNxt = IDLE;
          end else begin
            cntNxt = cnt - 3'd1;
          end
        end
        default: begin
          stateNxt = IDLE;
          cntNxt   = 3'd0;
        end
      endcase
    end
  end

  // Reset must drop stall at once, even with a hazard on the inputs.
  assign bus.stall = stallRaw & rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      statQ <= '0;
    end else if (stallRaw && (statQ != '1)) begin
      statQ <= statQ + ONE;
    end
  end

  assign bus.stallCnt = statQ;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: three instances (MEM_LAT 2/3/0) driven
// by one directed stimulus, checked against a behavioural model.
module tb_fwd_hazard_unit;

  typedef struct packed {
    logic [4:0] IdRs;
    logic [4:0] IdRt;
    logic       IdUsesRt;
    logic       ExMemRead;
    logic       ExWb;
    logic [4:0] ExRd;
    logic [4:0] ExRs;
    logic [4:0] ExRt;
    logic       MemWb;
    logic [4:0] MemRd;
    logic       WbWb;
    logic [4:0] WbRd;
    logic       flush;
  } stim_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  stim_t s = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit_if #(.REG_AW(5), .STAT_W(16)) ifA ();
  fwd_hazard_unit_if #(.REG_AW(5), .STAT_W(4))  ifB ();
  fwd_hazard_unit_if #(.REG_AW(5), .STAT_W(16)) ifC ();

  assign {ifA.IdRs, ifA.IdRt, ifA.IdUsesRt, ifA.ExMemRead,
          ifA.ExWb, ifA.ExRd, ifA.ExRs, ifA.ExRt, ifA.MemWb,
          ifA.MemRd, ifA.WbWb, ifA.WbRd, ifA.flush} = s;
  assign {ifB.IdRs, ifB.IdRt, ifB.IdUsesRt, ifB.ExMemRead,
          ifB.ExWb, ifB.ExRd, ifB.ExRs, ifB.ExRt, ifB.MemWb,
          ifB.MemRd, ifB.WbWb, ifB.WbRd, ifB.flush} = s;
  assign {ifC.IdRs, ifC.IdRt, ifC.IdUsesRt, ifC.ExMemRead,
          ifC.ExWb, ifC.ExRd, ifC.ExRs, ifC.ExRt, ifC.MemWb,
          ifC.MemRd, ifC.WbWb, ifC.WbRd, ifC.flush} = s;

  fwd_hazard_unit #(.REG_AW(5), .MEM_LAT(2), .STAT_W(16)) dutA (
    .clk(clk), .rst(rst), .bus(ifA)
  );
  fwd_hazard_unit #(.REG_AW(5), .MEM_LAT(3), .STAT_W(4)) dutB (
    .clk(clk), .rst(rst), .bus(ifB)
  );
  fwd_hazard_unit #(.REG_AW(5), .MEM_LAT(0), .STAT_W(16)) dutC (
    .clk(clk), .rst(rst), .bus(ifC)
  );

  logic [1:0]  gSelA [3];
  logic [1:0]  gSelB [3];
  logic        gStall[3];
  logic [31:0] gCnt  [3];

  assign gSelA[0] = ifA.selA;
  assign gSelA[1] = ifB.selA;
  assign gSelA[2] = ifC.selA;
  assign gSelB[0] = ifA.selB;
  assign gSelB[1] = ifB.selB;
  assign gSelB[2] = ifC.selB;
  assign gStall[0] = ifA.stall;
  assign gStall[1] = ifB.stall;
  assign gStall[2] = ifC.stall;
  assign gCnt[0] = 32'(ifA.stallCnt);
  assign gCnt[1] = 32'(ifB.stallCnt);
  assign gCnt[2] = 32'(ifC.stallCnt);

  // Model: per instance, stall cycles still owed after the current one,
  // and the stall total clipped to the counter's range.
  int lat[3]  = '{2, 3, 0};
  int smax[3] = '{65535, 15, 65535};
  int rem[3]  = '{0, 0, 0};
  int stat[3] = '{0, 0, 0};

  function automatic logic [1:0] expSel(logic [4:0] src);
    if (s.MemWb && s.MemRd != 0 && s.MemRd == src) return 2'b01;
    if (s.WbWb && s.WbRd != 0 && s.WbRd == src) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic expHazard();
    if (!(s.ExMemRead && s.ExWb) || s.ExRd == 0) return 1'b0;
    if (s.ExRd == s.IdRs) return 1'b1;
    return s.IdUsesRt && (s.ExRd == s.IdRt);
  endfunction

  function automatic logic expStall(int i);
    if (!rst || s.flush) return 1'b0;
    if (rem[i] > 0) return 1'b1;
    return expHazard();
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        rem[i]  <= 0;
        stat[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (expStall(i) && stat[i] < smax[i]) stat[i] <= stat[i] + 1;
        if (s.flush) rem[i] <= 0;
        else if (rem[i] > 0) rem[i] <= rem[i] - 1;
        else if (expHazard()) rem[i] <= lat[i];
      end
    end
  end

  task automatic chk(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("model selA[%0d]", i), int'(gSelA[i]),
          int'(expSel(s.ExRs)));
      chk($sformatf("model selB[%0d]", i), int'(gSelB[i]),
          int'(expSel(s.ExRt)));
      chk($sformatf("model stall[%0d]", i), int'(gStall[i]),
          int'(expStall(i)));
      chk($sformatf("model stallCnt[%0d]", i), int'(gCnt[i]), stat[i]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic loadUse(logic [4:0] rd, logic [4:0] rs,
                         logic [4:0] rt, logic usesRt);
    s = '0;
    s.ExMemRead = 1'b1;
    s.ExWb      = 1'b1;
    s.ExRd      = rd;
    s.IdRs      = rs;
    s.IdRt      = rt;
    s.IdUsesRt  = usesRt;
  endtask

  // Counts stall cycles per instance: current (hazard) cycle, then bubbles.
  task automatic episode(output int c0, output int c1, output int c2);
    c0 = 0;
    c1 = 0;
    c2 = 0;
    for (int k = 0; k < 7; k++) begin
      #1;
      c0 += int'(gStall[0]);
      c1 += int'(gStall[1]);
      c2 += int'(gStall[2]);
      tick();
      s = '0;
    end
  endtask

  int c0, c1, c2;

  initial begin
    #1 rst = 1'b0;
    #2;
    chk("reset stall A", int'(gStall[0]), 0);
    chk("reset stall B", int'(gStall[1]), 0);
    chk("reset stallCnt A", int'(gCnt[0]), 0);
    chk("reset stallCnt B", int'(gCnt[1]), 0);
    s.MemWb = 1'b1;
    s.MemRd = 5'd3;
    s.ExRs  = 5'd3;
    #1;
    chk("fwd during reset selA", int'(gSelA[0]), 1);
    s = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();

    s.MemWb = 1'b1;
    s.MemRd = 5'd3;
    s.WbWb  = 1'b1;
    s.WbRd  = 5'd3;
    s.ExRs  = 5'd3;
    s.ExRt  = 5'd3;
    #1;
    chk("fwd mem prio selA", int'(gSelA[0]), 1);
    chk("fwd mem prio selB", int'(gSelB[0]), 1);
    tick();
    s.MemWb = 1'b0;
    #1;
    chk("fwd wb selA", int'(gSelA[0]), 2);
    chk("fwd wb selB", int'(gSelB[0]), 2);
    tick();
    s.MemWb = 1'b1;
    s.MemRd = 5'd0;
    s.WbRd  = 5'd0;
    s.ExRs  = 5'd0;
    s.ExRt  = 5'd0;
    #1;
    chk("fwd r0 selA", int'(gSelA[0]), 0);
    chk("fwd r0 selB", int'(gSelB[0]), 0);
    tick();
    s = '0;
    tick();

    loadUse(5'd5, 5'd5, 5'd0, 1'b0);
    episode(c0, c1, c2);
    chk("loaduse len lat2", c0, 3);
    chk("loaduse len lat3", c1, 4);
    chk("loaduse len lat0", c2, 1);
    chk("loaduse stallCnt lat2", int'(gCnt[0]), 3);
    chk("loaduse stallCnt lat3", int'(gCnt[1]), 4);

    loadUse(5'd5, 5'd5, 5'd5, 1'b1);
    episode(c0, c1, c2);
    chk("both src len lat2", c0, 3);
    chk("both src len lat3", c1, 4);
    chk("both src stallCnt lat2", int'(gCnt[0]), 6);

    loadUse(5'd7, 5'd0, 5'd7, 1'b0);
    #1;
    chk("rt gated off", int'(gStall[0]), 0);
    s.IdUsesRt = 1'b1;
    #1;
    chk("rt gated on", int'(gStall[0]), 1);
    tick();
    s = '0;
    repeat (6) tick();

    loadUse(5'd0, 5'd0, 5'd0, 1'b1);
    #1;
    chk("rd0 no stall", int'(gStall[0]), 0);
    tick();
    s = '0;
    tick();

    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    loadUse(5'd9, 5'd9, 5'd0, 1'b0);
    #1;
    chk("flush pre stall", int'(gStall[1]), 1);
    tick();
    s = '0;
    s.flush = 1'b1;
    #1;
    chk("flush drops stall", int'(gStall[1]), 0);
    tick();
    s.flush = 1'b0;
    #1;
    chk("flush then idle", int'(gStall[1]), 0);
    chk("flush stallCnt", int'(gCnt[1]), 1);
    tick();

    loadUse(5'd4, 5'd4, 5'd0, 1'b0);
    tick();
    s = '0;
    #1;
    chk("mid stall before rst", int'(gStall[1]), 1);
    rst = 1'b0;
    #1;
    chk("async rst stall", int'(gStall[1]), 0);
    chk("async rst stallCnt B", int'(gCnt[1]), 0);
    chk("async rst stallCnt A", int'(gCnt[0]), 0);
    tick();
    rst = 1'b1;
    tick();
    tick();
    chk("post rst no stall", int'(gStall[1]), 0);

    loadUse(5'd6, 5'd6, 5'd0, 1'b0);
    repeat (20) tick();
    chk("sat reach 15", int'(gCnt[1]), 15);
    repeat (4) tick();
    chk("sat hold 15", int'(gCnt[1]), 15);
    chk("held stallCnt lat2", int'(gCnt[0]), 24);
    s = '0;
    repeat (6) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
